identify_pair_queue: RTL and testbench

// - Successor Identify stage between fetch arbiter and issue.
// - Accepts 32-bit fetched words over a valid/ready handshake.
// - Pairs a POWER v3.1 prefix word (primary opcode 1) with its following suffix word.
// - Classifies each instruction (branch / condreg / unknown) and queues the result
//   in a DEPTH-entry FIFO, drained by issue with valid/ready.

---
 rtl/identify_pair_queue.sv | 189 ++++++++++++++++++
 tb/tb_identify_pair_queue.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/identify_pair_queue.sv
// rtl/identify_pair_queue.sv - identify stage: prefix pairing, branch/CR classification, result FIFO
// Optional prefix pairing enabled by defining IDENTIFY_PREFIX_EN.
module identify_pair_queue #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [0:31] i_instr,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [0:31] o_instr_prefix,
    output logic [0:31] o_instr_suffix,
    output logic        o_prefixed,
    output logic        o_prefix_err,
    output logic        o_branch,
    output logic        o_condreg,
    output logic        o_unknown,
    output logic [3:0]  o_op
);

    typedef struct packed {
        logic [31:0] prefix;
        logic [31:0] suffix;
        logic        prefixed;
        logic        prefix_err;
        logic        branch;
        logic        condreg;
        logic        unknown;
        logic [3:0]  op;
    } entry_t;

    localparam entry_t C_EMPTY = entry_t'({69'd0, 4'hF});
    localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_ready;

    logic [5:0]       w_opc;
    logic [9:0]       w_xo;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W:0]   w_count_nxt;
    entry_t           w_entry;

    assign w_opc    = i_instr[0:5];
    assign w_xo     = i_instr[21:30];
    assign w_accept = i_valid & r_ready;
    assign w_pop    = (r_count != '0) & i_ready;

    // Prefixed pairs are never decoded further: they always classify as unknown.
    function automatic entry_t f_classify(input logic [31:0] pfx, input logic [31:0] word,
                                          input logic [5:0] opc, input logic [9:0] xo,
                                          input logic prefixed, input logic err);
        entry_t e;
        e            = C_EMPTY;
        e.prefix     = pfx;
        e.suffix     = word;
        e.prefixed   = prefixed;
        e.prefix_err = err;
        e.unknown    = 1'b1;
        if (!prefixed) begin
            case (opc)
                6'd18: begin e.branch = 1'b1; e.unknown = 1'b0; e.op = 4'd0; end
                6'd16: begin e.branch = 1'b1; e.unknown = 1'b0; e.op = 4'd1; end
                6'd19: begin
                    case (xo)
                        10'd16:  begin e.branch  = 1'b1; e.unknown = 1'b0; e.op = 4'd2;  end
                        10'd528: begin e.branch  = 1'b1; e.unknown = 1'b0; e.op = 4'd3;  end
                        10'd560: begin e.branch  = 1'b1; e.unknown = 1'b0; e.op = 4'd4;  end
                        10'd257: begin e.condreg = 1'b1; e.unknown = 1'b0; e.op = 4'd5;  end
                        10'd225: begin e.condreg = 1'b1; e.unknown = 1'b0; e.op = 4'd6;  end
                        10'd449: begin e.condreg = 1'b1; e.unknown = 1'b0; e.op = 4'd7;  end
                        10'd193: begin e.condreg = 1'b1; e.unknown = 1'b0; e.op = 4'd8;  end
                        10'd33:  begin e.condreg = 1'b1; e.unknown = 1'b0; e.op = 4'd9;  end
                        10'd289: begin e.condreg = 1'b1; e.unknown = 1'b0; e.op = 4'd10; end
                        10'd129: begin e.condreg = 1'b1; e.unknown = 1'b0; e.op = 4'd11; end
                        10'd417: begin e.condreg = 1'b1; e.unknown = 1'b0; e.op = 4'd12; end
                        10'd0:   begin e.condreg = 1'b1; e.unknown = 1'b0; e.op = 4'd13; end
                        default: e.op = 4'd15;
                    endcase
                end
                default: e.op = 4'd15;
            endcase
        end
        return e;
    endfunction

`ifdef IDENTIFY_PREFIX_EN
    typedef enum logic {S_IDLE, S_WAIT_SFX} state_t;
    state_t      r_state;
    logic [31:0] r_prefix;
    logic        w_is_pfx;

    assign w_is_pfx = (w_opc == 6'd1);

    always_comb begin
        w_push  = 1'b0;
        w_entry = f_classify(32'd0, i_instr, w_opc, w_xo, 1'b0, 1'b0);
        if (r_state == S_WAIT_SFX) begin
            w_push  = w_accept;
            w_entry = f_classify(r_prefix, i_instr, w_opc, w_xo, 1'b1, w_is_pfx);
        end else begin
            w_push  = w_accept & ~w_is_pfx;
        end
    end
`else
    always_comb begin
        w_push  = w_accept;
        w_entry = f_classify(32'd0, i_instr, w_opc, w_xo, 1'b0, 1'b0);
    end
`endif

    assign w_count_nxt = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

    // o_ready is registered from the next count, so a pop while full frees space one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= C_EMPTY;
`ifdef IDENTIFY_PREFIX_EN
            r_state  <= S_IDLE;
            r_prefix <= '0;
`endif
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
`ifdef IDENTIFY_PREFIX_EN
            r_state  <= S_IDLE;
            r_prefix <= '0;
`endif
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != C_FULL);
`ifdef IDENTIFY_PREFIX_EN
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_is_pfx) begin
                            r_prefix <= i_instr;
                            r_state  <= S_WAIT_SFX;
                        end
                    end
                    S_WAIT_SFX: begin
                        r_prefix <= '0;
                        r_state  <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
`endif
        end
    end

    assign o_ready        = r_ready;
    assign o_valid        = (r_count != '0);
    assign o_instr_suffix = r_mem[r_rd_ptr].suffix;
    assign o_branch       = r_mem[r_rd_ptr].branch;
    assign o_condreg      = r_mem[r_rd_ptr].condreg;
    assign o_unknown      = r_mem[r_rd_ptr].unknown;
    assign o_op           = r_mem[r_rd_ptr].op;
`ifdef IDENTIFY_PREFIX_EN
    assign o_instr_prefix = r_mem[r_rd_ptr].prefix;
    assign o_prefixed     = r_mem[r_rd_ptr].prefixed;
    assign o_prefix_err   = r_mem[r_rd_ptr].prefix_err;
`else
    assign o_instr_prefix = '0;
    assign o_prefixed     = 1'b0;
    assign o_prefix_err   = 1'b0;
`endif

endmodule

// File: tb/tb_identify_pair_queue.sv
// tb/tb_identify_pair_queue.sv - directed self-checking bench for identify_pair_queue
module tb_identify_pair_queue;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [0:31] instr;
    logic        out_ready, out_valid;
    logic [0:31] pfx, sfx;
    logic        prefixed, perr, br, cr, unk;
    logic [3:0]  op;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    identify_pair_queue #(.DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(out_ready),
        .i_instr(instr), .o_valid(out_valid), .i_ready(in_ready),
        .o_instr_prefix(pfx), .o_instr_suffix(sfx), .o_prefixed(prefixed),
        .o_prefix_err(perr), .o_branch(br), .o_condreg(cr), .o_unknown(unk), .o_op(op)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] e_pfx, input logic [31:0] e_sfx,
                              input logic e_pfxd, input logic e_err, input logic e_br,
                              input logic e_cr, input logic e_unk, input logic [3:0] e_op);
        check({tag, ".valid"},    64'(out_valid), 64'd1);
        check({tag, ".prefix"},   64'(pfx),       64'(e_pfx));
        check({tag, ".suffix"},   64'(sfx),       64'(e_sfx));
        check({tag, ".prefixed"}, 64'(prefixed),  64'(e_pfxd));
        check({tag, ".err"},      64'(perr),      64'(e_err));
        check({tag, ".branch"},   64'(br),        64'(e_br));
        check({tag, ".condreg"},  64'(cr),        64'(e_cr));
        check({tag, ".unknown"},  64'(unk),       64'(e_unk));
        check({tag, ".op"},       64'(op),        64'(e_op));
    endtask

    task automatic push(input logic [31:0] w);
        in_valid = 1'b1;
        instr    = w;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        in_ready = 1'b1;
        step();
        in_ready = 1'b0;
    endtask

    logic [31:0] words [5];
    logic [3:0]  ops   [5];
    int          acc;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ready = 1'b0; instr = '0;
        step();
        step();
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.ready", 64'(out_ready), 64'd0);
        check("rst.branch", 64'(br), 64'd0);
        check("rst.unknown", 64'(unk), 64'd0);
        check("rst.op", 64'(op), 64'd15);
        check("rst.suffix", 64'(sfx), 64'd0);
        rst = 1'b0;
        step();
        check("post_rst.ready", 64'(out_ready), 64'd1);
        check("post_rst.valid", 64'(out_valid), 64'd0);

        push(32'h48032BFB);
        check_head("b_i", 32'h0, 32'h48032BFB, 0, 0, 1, 0, 0, 4'd0);
        pop();
        check("b_i.drained", 64'(out_valid), 64'd0);

        // Second push overlaps a pop of the first: count stays at one.
        push(32'h4E800020);
        in_valid = 1'b1; instr = 32'h4C000182; in_ready = 1'b1;
        check_head("bclr", 32'h0, 32'h4E800020, 0, 0, 1, 0, 0, 4'd2);
        step();
        in_valid = 1'b0; in_ready = 1'b0;
        check_head("crxor", 32'h0, 32'h4C000182, 0, 0, 0, 1, 0, 4'd8);
        pop();
        check("crxor.drained", 64'(out_valid), 64'd0);

`ifdef IDENTIFY_PREFIX_EN
        push(32'h06000000);
        check("pfx.held", 64'(out_valid), 64'd0);
        push(32'h38600000);
        check_head("pair", 32'h06000000, 32'h38600000, 1, 0, 0, 0, 1, 4'd15);
        pop();
        check("pair.drained", 64'(out_valid), 64'd0);
        push(32'h06000000);
        push(32'h06000000);
        check_head("pair_err", 32'h06000000, 32'h06000000, 1, 1, 0, 0, 1, 4'd15);
        pop();
        check("pair_err.drained", 64'(out_valid), 64'd0);
`else
        push(32'h06000000);
        check_head("op1_plain", 32'h0, 32'h06000000, 0, 0, 0, 0, 1, 4'd15);
        pop();
        push(32'h38600000);
        check_head("addi_plain", 32'h0, 32'h38600000, 0, 0, 0, 0, 1, 4'd15);
        pop();
        check("plain.drained", 64'(out_valid), 64'd0);
`endif

        words[0] = 32'h48000000; ops[0] = 4'd0;
        words[1] = 32'h4E800420; ops[1] = 4'd3;
        words[2] = 32'h40820010; ops[2] = 4'd1;
        words[3] = 32'h4C000000; ops[3] = 4'd13;
        words[4] = 32'h4C000202; ops[4] = 4'd5;
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            instr = words[acc];
            check($sformatf("full.ready%0d", i), 64'(out_ready), (i < 4) ? 64'd1 : 64'd0);
            if (out_ready) acc++;
            step();
        end
        check("full.accepted", 64'(acc), 64'd4);
        instr = words[4];
        in_ready = 1'b1;
        check("full.ready_at_pop", 64'(out_ready), 64'd0);
        step();
        in_ready = 1'b0;
        check("full.ready_after_pop", 64'(out_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("full.ready_refull", 64'(out_ready), 64'd0);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("drain%0d.suffix", i), 64'(sfx), 64'(words[i]));
            check($sformatf("drain%0d.op", i), 64'(op), 64'(ops[i]));
            pop();
        end
        check("drain.empty", 64'(out_valid), 64'd0);

        push(32'h06000000);
        flush = 1'b1; in_valid = 1'b1; instr = 32'h48000000;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush.valid", 64'(out_valid), 64'd0);
        check("flush.ready", 64'(out_ready), 64'd1);
        step();
        check("flush.still_empty", 64'(out_valid), 64'd0);
        push(32'h4E800020);
        check_head("after_flush", 32'h0, 32'h4E800020, 0, 0, 1, 0, 0, 4'd2);
        pop();
        check("after_flush.drained", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
